// File: rtl/volatility_window_ctrl.sv
// Per-stock circular-buffer address controller for the shared volatility sample RAM.
// Writes: 1-cycle registered, never stalled. Sweeps: one beat per accepted cycle, held while i_rd_ready is low.
module volatility_window_ctrl #(
  parameter int NUM_STOCKS  = 4,
  parameter int BUFFER_SIZE = 20,
  parameter int MIN_FILL    = 2,
  parameter int AW          = $clog2(NUM_STOCKS * BUFFER_SIZE),
  parameter int SW          = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1,
  parameter int CW          = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [SW-1:0]         i_stock_id,
  input  logic                  i_data_valid,
  input  logic                  i_clear_valid,
  input  logic [SW-1:0]         i_clear_stock_id,
  output logic                  o_write_en,
  output logic [AW-1:0]         o_write_address,
  output logic [NUM_STOCKS-1:0] o_full,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic [AW-1:0]         o_rd_address,
  output logic [SW-1:0]         o_rd_stock_id,
  output logic [CW-1:0]         o_rd_count,
  output logic                  o_rd_last
);

  localparam int XW = AW + 1;

  typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           wo_q  [NUM_STOCKS];
  logic [CW-1:0]           wo_d  [NUM_STOCKS];
  logic [CW-1:0]           cnt_q [NUM_STOCKS];
  logic [CW-1:0]           cnt_d [NUM_STOCKS];
  logic [NUM_STOCKS-1:0]   full_q, full_d;
  logic [NUM_STOCKS-1:0]   pending_q, pending_d;
  logic                    wr_en_q, wr_en_d;
  logic [AW-1:0]           wr_addr_q, wr_addr_d;
  logic [SW-1:0]           g_q, g_d;
  logic [CW-1:0]           start_q, start_d;
  logic [CW-1:0]           len_q, len_d;
  logic [CW-1:0]           idx_q, idx_d;

  logic                    sweeping;
  logic                    rd_last;
  logic                    sweep_clr;
  logic                    grant_vld;
  logic [SW-1:0]           grant_idx;
  logic [NUM_STOCKS-1:0]   clr_mask;
  logic [XW-1:0]           pos_sum;
  logic [XW-1:0]           pos_wrap;

  // Out-of-range stock ids match no slot, so they are silently ignored.
  always_comb begin
    clr_mask = '0;
    for (int s = 0; s < NUM_STOCKS; s++) begin
      clr_mask[s] = i_clear_valid && (i_clear_stock_id == SW'(s));
    end
  end

  // A stock being cleared this cycle is not granted; its window is about to vanish.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int s = NUM_STOCKS - 1; s >= 0; s--) begin
      if (pending_q[s] && !clr_mask[s]) begin
        grant_vld = 1'b1;
        grant_idx = SW'(s);
      end
    end
  end

  assign sweeping  = (state_q == ST_SWEEP);
  assign pos_sum   = XW'(start_q) + XW'(idx_q);
  assign pos_wrap  = (pos_sum >= XW'(BUFFER_SIZE)) ? (pos_sum - XW'(BUFFER_SIZE)) : pos_sum;
  assign rd_last   = sweeping && (idx_q == (len_q - CW'(1)));
  assign sweep_clr = i_clear_valid && (i_clear_stock_id == g_q);

  always_comb begin
    state_d   = state_q;
    wo_d      = wo_q;
    cnt_d     = cnt_q;
    full_d    = full_q;
    pending_d = pending_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    g_d       = g_q;
    start_d   = start_q;
    len_d     = len_q;
    idx_d     = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          state_d              = ST_SWEEP;
          g_d                  = grant_idx;
          len_d                = cnt_q[grant_idx];
          start_d              = (cnt_q[grant_idx] == CW'(BUFFER_SIZE)) ? wo_q[grant_idx] : '0;
          idx_d                = '0;
          pending_d[grant_idx] = 1'b0;
        end
      end
      ST_SWEEP: begin
        if (sweep_clr) begin
          state_d = ST_IDLE;
        end else if (i_rd_ready) begin
          idx_d = idx_q + CW'(1);
          if (rd_last) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Write path runs after the grant so a same-cycle write re-arms pending.
    for (int s = 0; s < NUM_STOCKS; s++) begin
      if (i_data_valid && (i_stock_id == SW'(s)) && !clr_mask[s]) begin
        wr_en_d   = 1'b1;
        wr_addr_d = AW'(XW'(s * BUFFER_SIZE) + XW'(wo_q[s]));
        wo_d[s]   = (wo_q[s] == CW'(BUFFER_SIZE - 1)) ? '0 : (wo_q[s] + CW'(1));
        cnt_d[s]  = (cnt_q[s] == CW'(BUFFER_SIZE)) ? cnt_q[s] : (cnt_q[s] + CW'(1));
        if (cnt_d[s] >= CW'(MIN_FILL)) begin
          pending_d[s] = 1'b1;
        end
      end
    end

    for (int s = 0; s < NUM_STOCKS; s++) begin
      if (clr_mask[s]) begin
        wo_d[s]      = '0;
        cnt_d[s]     = '0;
        pending_d[s] = 1'b0;
      end
      full_d[s] = (cnt_d[s] == CW'(BUFFER_SIZE));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      full_q    <= '0;
      pending_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      g_q       <= '0;
      start_q   <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      for (int s = 0; s < NUM_STOCKS; s++) begin
        wo_q[s]  <= '0;
        cnt_q[s] <= '0;
      end
    end else begin
      state_q   <= state_d;
      full_q    <= full_d;
      pending_q <= pending_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      g_q       <= g_d;
      start_q   <= start_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      wo_q      <= wo_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_write_en      = wr_en_q;
  assign o_write_address = wr_addr_q;
  assign o_full          = full_q;
  assign o_rd_valid      = sweeping;
  assign o_rd_address    = sweeping ? AW'(XW'(g_q) * XW'(BUFFER_SIZE) + pos_wrap) : '0;
  assign o_rd_stock_id   = sweeping ? g_q : '0;
  assign o_rd_count      = sweeping ? len_q : '0;
  assign o_rd_last       = rd_last;

endmodule

// File: doc/volatility_window_ctrl.md
Name: volatility_window_ctrl

Overview:
Per-stock circular-buffer controller for the shared volatility sample RAM (NUM_STOCKS regions of BUFFER_SIZE entries each).
- Write path: generates the RAM write address and enable for each incoming sample, with correct per-region wrap and a per-stock fill count.
- Read-sweep path: streams the valid window of a stock, oldest to newest, to the downstream variance calculator under valid/ready handshake.
- Arbitration: sweeps are requested per stock and served lowest index first.

Parameters:
- NUM_STOCKS, 4, number of stocks/regions (>=1)
- BUFFER_SIZE, 20, entries per region (>=2)
- MIN_FILL, 2, minimum stored samples before a stock requests a sweep (1..BUFFER_SIZE)
- Derived: AW = $clog2(NUM_STOCKS*BUFFER_SIZE), SW = $clog2(NUM_STOCKS) (min 1), CW = $clog2(BUFFER_SIZE+1)

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_stock_id  in  SW  stock of incoming sample
- i_data_valid  in  1  sample present this cycle
- i_clear_valid  in  1  clear one stock's window
- i_clear_stock_id  in  SW  stock to clear
- o_write_en  out  1  RAM write strobe (registered)
- o_write_address  out  AW  RAM write address (registered)
- o_full  out  NUM_STOCKS  bit s = stock s holds BUFFER_SIZE samples
- o_rd_valid  out  1  sweep address valid
- i_rd_ready  in  1  downstream accepts sweep beat
- o_rd_address  out  AW  sweep RAM read address
- o_rd_stock_id  out  SW  stock being swept
- o_rd_count  out  CW  number of samples in this sweep
- o_rd_last  out  1  final beat of sweep

Behaviour:
- Reset: all outputs 0, all write offsets/counts 0, pending mask 0, FSM IDLE. Reset during a sweep aborts it; o_rd_valid is 0 the cycle after reset is sampled.
- Region base for stock s is s*BUFFER_SIZE. Per-stock write offset wo[s] is in 0..BUFFER_SIZE-1; count cnt[s] is in 0..BUFFER_SIZE.
- Write, one-cycle latency: i_data_valid at edge N gives o_write_en=1 and o_write_address=base+wo[s] (pre-increment value) after edge N.
  - wo[s] increments, wrapping BUFFER_SIZE-1 -> 0.
  - cnt[s] increments, saturating at BUFFER_SIZE.
  - o_full[s] = (cnt[s]==BUFFER_SIZE), registered.
  - Writes are never back-pressured; every valid sample is written, one per cycle max.
  - i_stock_id >= NUM_STOCKS: write ignored, o_write_en=0.
- Sweep request: a write that leaves cnt[s] >= MIN_FILL sets pending[s]. Requests for a stock already pending coalesce.
- FSM:
  - IDLE: if pending != 0, grant lowest set index g, clear pending[g], snapshot start = (cnt[g]==BUFFER_SIZE ? wo[g] : 0), len = cnt[g], idx = 0, go to SWEEP. Otherwise stay in IDLE.
  - SWEEP: o_rd_valid=1, o_rd_stock_id=g, o_rd_count=len, o_rd_address = base(g) + ((start+idx) mod BUFFER_SIZE), o_rd_last = (idx==len-1).
    - On o_rd_valid & i_rd_ready: idx++. If the beat is last, go to IDLE.
    - Outputs hold stable while i_rd_ready=0.
    - At least one IDLE cycle separates sweeps.
- Simultaneous events:
  - Write to g in the same cycle as its grant: the snapshot uses pre-write wo/cnt, and pending[g] is re-set (a fresh sweep follows).
  - Writes to g during its sweep do not alter the current sweep's addresses; they re-set pending[g].
- Clear of stock c:
  - Next cycle: wo[c]=0, cnt[c]=0, pending[c]=0, o_full[c]=0.
  - Clear and write to the same stock in the same cycle: clear wins, write dropped (o_write_en=0).
  - Clear of the stock being swept: sweep aborts, o_rd_valid=0 next cycle, no o_rd_last, FSM goes to IDLE.
  - Clear of any other stock does not disturb a sweep.
- Width rules: all address arithmetic is done in AW+1 bits then truncated. Modulo is implemented as a conditional subtract (start+idx < 2*BUFFER_SIZE); no divider.

Test Plan:
- Reset, then 21 writes to stock 2 -> o_write_address 40,41,...,59,40; o_full = 4'b0100 after write 20; cnt stays 20.
- 3 writes to stock 1, i_rd_ready=1 -> after write 2 a sweep of stock 1 (count 2: addr 20,21, last on 21), then another sweep (count 3: addr 20,21,22).
- Fill stock 0 with 23 writes, then idle and sweep -> 20 beats starting at addr 3, wrapping 19 -> 0, ending at 2, o_rd_last on addr 2.
- Pending on stocks 3 and 1 at the same time, with i_rd_ready toggling 1/0 -> stock 1 swept first, then stock 3; address held stable on every ready=0 cycle.
- Clear stock 1 at sweep beat 1 of stock 1 -> o_rd_valid=0 next cycle, no o_rd_last; next write to stock 1 goes to addr 20.
- Assert reset mid-sweep and mid-write -> all outputs 0 next cycle; the first write to stock 3 after reset goes to addr 60.
